// File: rtl/mem_access_if.sv
// Core-side load/store handshake and data-memory port of mem_access_unit, bundled as one interface.
// slave: the access unit's view. master: the core/memory side's view.
interface mem_access_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic [15:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data memory; one request in flight, byte stores via RMW.
// Optional MEMACC_ALIGN_CHECK_EN: reject word accesses at even addresses with rsp_err.
module mem_access_unit #(
    parameter int ADDR_W   = 14,
    parameter int HOLD_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RD    | memory read phase, mem_rdata captured on last hold cycle
    // WR    | memory write phase, mem_we high for HOLD_CYC cycles
    // RESP  | response presented until rsp_ready
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic [7:0]        bdata_q, bdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              reject;

`ifdef MEMACC_ALIGN_CHECK_EN
    // A==0 has bit 0 clear, so the wrap case is rejected by the same test
    assign reject = !bus.req_byte && !bus.req_addr[0];
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        byte_d      = byte_q;
        bdata_d     = bdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    byte_d     = bus.req_byte;
                    bdata_d    = bus.req_wdata[7:0];
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b0;
                    cnt_d      = CNT_LOAD;
                    if (reject) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        mem_addr_d = bus.req_addr;
                        if (bus.req_we && !bus.req_byte) begin
                            mem_wdata_d = bus.req_wdata;
                            mem_we_d    = 1'b1;
                            state_d     = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        // high lane takes the new byte, low lane keeps mem[A-1]
                        mem_wdata_d = {bdata_q, bus.mem_rdata[7:0]};
                        mem_we_d    = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = WR;
                    end else begin
                        rsp_data_d = byte_q ? {8'h00, bus.mem_rdata[15:8]} : bus.mem_rdata;
                        state_d    = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR: begin
                if (cnt_q == '0) begin
                    mem_we_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            bdata_q     <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
            mem_we_q    <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            bdata_q     <= bdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (HOLD_CYC 1 and 3) driven in lockstep, each with its own
// byte memory, checked against a byte-array reference model of load/store semantics.
module tb_mem_access_unit;
    localparam int K_ERR = 0, K_LD = 1, K_WST = 2, K_BST = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, rsp_ready = 1'b0;
    logic [13:0] req_addr = '0, peek_addr = '0;
    logic [15:0] req_wdata = '0;

    int tests = 0, fails = 0;
    logic [7:0]  ref_mem [0:16383];
    int          exp_kind;
    logic [15:0] exp_data, exp_wdata;
    logic [13:0] exp_addr;
    logic        exp_err;

    wire [1:0]       lane_done, lane_busy, lane_rv;
    wire [1:0]       l_req_ready, l_rsp_valid, l_rsp_err, l_mem_we;
    wire [1:0][15:0] l_rsp_data, l_mem_wdata;
    wire [1:0][13:0] l_mem_addr;
    wire [1:0][7:0]  l_peek;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 29 + 7) ^ 8'(i >> 7);
    endfunction

    function automatic int exp_lat(input int k, input int h);
        case (k)
            K_ERR:   return 1;
            K_BST:   return 1 + 2 * h;
            default: return 1 + h;
        endcase
    endfunction

    function automatic int exp_wecnt(input int k, input int h);
        return (k == K_WST || k == K_BST) ? h : 0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int H = (g == 0) ? 1 : 3;
        mem_access_if #(.ADDR_W(14)) bus ();
        mem_access_unit #(.ADDR_W(14), .HOLD_CYC(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

        logic [7:0]  dmem [0:16383];
        wire  [13:0] am1 = bus.mem_addr - 14'd1;
        initial for (int i = 0; i < 16384; i++) dmem[i] = init_byte(i);
        always @(posedge clk) if (bus.mem_we) begin
            dmem[bus.mem_addr] = bus.mem_wdata[15:8];
            dmem[am1]          = bus.mem_wdata[7:0];
        end

        assign bus.mem_rdata = {dmem[bus.mem_addr], dmem[am1]};
        assign bus.req_valid = req_valid;
        assign bus.req_we    = req_we;
        assign bus.req_byte  = req_byte;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign bus.rsp_ready = rsp_ready;

        assign l_req_ready[g] = bus.req_ready;
        assign l_rsp_valid[g] = bus.rsp_valid;
        assign l_rsp_err[g]   = bus.rsp_err;
        assign l_mem_we[g]    = bus.mem_we;
        assign l_rsp_data[g]  = bus.rsp_data;
        assign l_mem_wdata[g] = bus.mem_wdata;
        assign l_mem_addr[g]  = bus.mem_addr;
        assign l_peek[g]      = dmem[peek_addr];

        bit busy = 0, seen = 0, done = 0;
        int t = 0, we_cnt = 0;
        assign lane_busy[g] = busy;
        assign lane_done[g] = done;
        assign lane_rv[g]   = seen;

        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy = 0; seen = 0; done = 0;
            end else if (busy) begin
                t++;
                if (bus.mem_we) begin
                    we_cnt++;
                    chk($sformatf("L%0d wr_addr", g), 32'(bus.mem_addr), 32'(exp_addr));
                    chk($sformatf("L%0d wr_data", g), 32'(bus.mem_wdata), 32'(exp_wdata));
                end
                if (bus.rsp_valid) begin
                    if (!seen) begin
                        seen = 1;
                        chk($sformatf("L%0d latency", g), 32'(t), 32'(exp_lat(exp_kind, H)));
                    end
                    chk($sformatf("L%0d rsp_data", g), 32'(bus.rsp_data), 32'(exp_data));
                    chk($sformatf("L%0d rsp_err", g), 32'(bus.rsp_err), 32'(exp_err));
                    chk($sformatf("L%0d ready_busy", g), 32'(bus.req_ready), 0);
                    if (bus.rsp_ready) begin
                        chk($sformatf("L%0d we_cycles", g), 32'(we_cnt), 32'(exp_wecnt(exp_kind, H)));
                        busy = 0;
                        done = 1;
                    end
                end
            end else begin
                if (bus.rsp_valid || bus.mem_we)
                    chk($sformatf("L%0d idle_quiet", g), {30'b0, bus.rsp_valid, bus.mem_we}, 0);
                if (bus.req_valid && bus.req_ready) begin
                    busy = 1; seen = 0; done = 0; t = 0; we_cnt = 0;
                end
            end
        end
    end

    task automatic model(input bit we, input bit byt, input logic [13:0] a, input logic [15:0] wd);
        logic [13:0] am1;
        bit          err;
        am1 = a - 14'd1;
`ifdef MEMACC_ALIGN_CHECK_EN
        err = !byt && (a % 2 == 0);
`else
        err = 0;
`endif
        exp_err = err; exp_data = 16'h0; exp_addr = a; exp_wdata = 16'h0;
        if (err) begin
            exp_kind = K_ERR;
        end else if (!we) begin
            exp_kind = K_LD;
            exp_data = byt ? {8'h00, ref_mem[a]} : {ref_mem[a], ref_mem[am1]};
        end else if (!byt) begin
            exp_kind  = K_WST;
            exp_wdata = wd;
            ref_mem[a] = wd[15:8];
            ref_mem[am1] = wd[7:0];
        end else begin
            exp_kind  = K_BST;
            exp_wdata = {wd[7:0], ref_mem[am1]};
            ref_mem[a] = wd[7:0];
        end
    endtask

    task automatic do_txn(input bit we, input bit byt, input logic [13:0] a,
                          input logic [15:0] wd, input bit stall);
        int n;
        model(we, byt, a, wd);
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_byte = byt; req_addr = a; req_wdata = wd;
        rsp_ready = !stall;
        @(posedge clk); #1;
        chk("accept", 32'(lane_busy), 3);
        if (stall) begin
            // a second request waits on the bus while the response is held off
            req_we = 1'($urandom); req_byte = 1'($urandom);
            req_addr = 14'($urandom); req_wdata = 16'($urandom);
            n = 0;
            while (lane_rv != 2'b11 && n < 60) begin @(posedge clk); #1; n++; end
            repeat (5) @(posedge clk);
            #1;
            req_valid = 0; rsp_ready = 1;
        end else begin
            req_valid = 0;
        end
        n = 0;
        while (lane_done != 2'b11 && n < 60) begin @(posedge clk); #1; n++; end
        chk("completion", 32'(lane_done), 3);
    endtask

    initial begin
        logic [13:0] a;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(l_req_ready[i]), 0);
            chk("rst_rsp_valid", 32'(l_rsp_valid[i]), 0);
            chk("rst_rsp_data", 32'(l_rsp_data[i]), 0);
            chk("rst_rsp_err", 32'(l_rsp_err[i]), 0);
            chk("rst_mem_we", 32'(l_mem_we[i]), 0);
            chk("rst_mem_addr", 32'(l_mem_addr[i]), 0);
            chk("rst_mem_wdata", 32'(l_mem_wdata[i]), 0);
        end
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", 32'(l_req_ready), 3);

        do_txn(1, 0, 14'h0011, 16'hBEEF, 0);
        do_txn(0, 0, 14'h0011, 16'h0000, 0);
        do_txn(1, 1, 14'h0011, 16'h0042, 0);
        do_txn(0, 0, 14'h0011, 16'h0000, 0);
        do_txn(0, 1, 14'h0011, 16'h0000, 0);
        do_txn(0, 0, 14'h0011, 16'h0000, 1);
        do_txn(1, 0, 14'h0010, 16'h1234, 0);
        do_txn(0, 0, 14'h0000, 16'h0000, 0);
        do_txn(1, 1, 14'h0000, 16'h00A5, 1);
        do_txn(0, 0, 14'h0001, 16'h0000, 0);

        // reset lands while both lanes are in their first write cycle: no edge sees mem_we
        exp_kind = K_WST; exp_addr = 14'h0021; exp_wdata = 16'hCAFE; exp_err = 0; exp_data = 0;
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_byte = 0; req_addr = 14'h0021; req_wdata = 16'hCAFE;
        rsp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        chk("we_before_rst", 32'(l_mem_we), 3);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        chk("rst_we_drop", 32'(l_mem_we), 0);
        chk("rst_rsp_valid_mid", 32'(l_rsp_valid), 0);
        chk("rst_ready_low", 32'(l_req_ready), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_abort", 32'(l_req_ready), 3);

        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 3) == 0) a = 14'h3FF8 + 14'($urandom_range(0, 7));
            else a = 14'($urandom_range(0, 31));
            do_txn(1'($urandom), 1'($urandom), a, 16'($urandom), $urandom_range(0, 4) == 0);
        end

        for (int i = 0; i < 48; i++) begin
            peek_addr = (i < 32) ? 14'(i) : 14'h3FF0 + 14'(i - 32);
            #1;
            chk("mem_l0", 32'(l_peek[0]), 32'(ref_mem[peek_addr]));
            chk("mem_l1", 32'(l_peek[1]), 32'(ref_mem[peek_addr]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
